block_mac_2x2: RTL and testbench

Responder side of the `start_mac`/`done_mac` handshake driven by the matrix-multiply control unit. It accepts one 2x2 A block and one 2x2 B block, then computes C = A·B, or C += A·B when accumulating over the k dimension. A single shared multiplier-adder performs one product per cycle. The result is presented on four registered C outputs for the control unit to write back to RAM.

---
 rtl/matrix_mul_pkg.sv | 14 +
 rtl/mac_step.sv | 27 ++
 rtl/block_mac_2x2.sv | 128 ++++++++++++
 tb/tb_block_mac_2x2.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/matrix_mul_pkg.sv
// rtl/matrix_mul_pkg.sv - shared types and constants for the matrix-multiply blocks
package matrix_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

  localparam int DEFAULT_DATA_W = 32;
  localparam int MAC_STEPS      = 8;
  localparam int MAC_LATENCY    = 9;

endpackage

// File: rtl/mac_step.sv
// rtl/mac_step.sv - combinational signed multiply-add with wrap and overflow flags
module mac_step #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic        [DATA_W-1:0] acc,
  output logic        [DATA_W-1:0] sum,
  output logic                     ovf_mul,
  output logic                     ovf_add
);

  logic signed [2*DATA_W-1:0] prod;
  logic        [DATA_W-1:0]   prod_lo;

  // Full-width signed product; only the low word feeds the accumulator.
  assign prod    = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign prod_lo = prod[DATA_W-1:0];
  assign sum     = acc + prod_lo;

  // The product fits a signed word only if its top DATA_W+1 bits all equal the sign.
  assign ovf_mul = (prod[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod[DATA_W-1]}});

  // Like-signed addends producing an opposite-signed sum.
  assign ovf_add = (acc[DATA_W-1] == prod_lo[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]);

endmodule

// File: rtl/block_mac_2x2.sv
// rtl/block_mac_2x2.sv - 2x2 block multiply/accumulate responder for the matmul control unit
module block_mac_2x2
  import matrix_mul_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              acc_clr,
  input  logic [DATA_W-1:0] a_11,
  input  logic [DATA_W-1:0] a_12,
  input  logic [DATA_W-1:0] a_21,
  input  logic [DATA_W-1:0] a_22,
  input  logic [DATA_W-1:0] b_11,
  input  logic [DATA_W-1:0] b_12,
  input  logic [DATA_W-1:0] b_21,
  input  logic [DATA_W-1:0] b_22,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] c_11,
  output logic [DATA_W-1:0] c_12,
  output logic [DATA_W-1:0] c_21,
  output logic [DATA_W-1:0] c_22,
  output logic              ovf
);

  mac_state_t        state;
  logic [2:0]        s;

  // Operand, accumulator and result words are indexed {row, col}: 0=11, 1=12, 2=21, 3=22.
  logic [DATA_W-1:0] a_r   [4];
  logic [DATA_W-1:0] b_r   [4];
  logic [DATA_W-1:0] acc_r [4];
  logic [DATA_W-1:0] c_r   [4];

  logic [1:0]        a_idx;
  logic [1:0]        b_idx;
  logic [1:0]        acc_idx;
  logic [DATA_W-1:0] step_sum;
  logic              step_ovf_mul;
  logic              step_ovf_add;

  // Step s decodes to i=s[2], j=s[1], k=s[0]: acc_ij += a_ik * b_kj.
  assign a_idx   = {s[2], s[0]};
  assign b_idx   = {s[0], s[1]};
  assign acc_idx = {s[2], s[1]};

  mac_step #(
    .DATA_W (DATA_W)
  ) u_mac_step (
    .a       (a_r[a_idx]),
    .b       (b_r[b_idx]),
    .acc     (acc_r[acc_idx]),
    .sum     (step_sum),
    .ovf_mul (step_ovf_mul),
    .ovf_add (step_ovf_add)
  );

  assign c_11 = c_r[0];
  assign c_12 = c_r[1];
  assign c_21 = c_r[2];
  assign c_22 = c_r[3];

  // Control FSM: capture in IDLE, eight multiply-add steps, one-cycle done with result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        a_r[n]   <= '0;
        b_r[n]   <= '0;
        acc_r[n] <= '0;
        c_r[n]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r[0] <= a_11;
            a_r[1] <= a_12;
            a_r[2] <= a_21;
            a_r[3] <= a_22;
            b_r[0] <= b_11;
            b_r[1] <= b_12;
            b_r[2] <= b_21;
            b_r[3] <= b_22;
            s      <= 3'd0;
            busy   <= 1'b1;
            state  <= MUL;
            // First k-block: start from zero and forget earlier overflow.
            if (acc_clr) begin
              for (int n = 0; n < 4; n++) acc_r[n] <= '0;
              ovf <= 1'b0;
            end
          end
        end
        MUL: begin
          acc_r[acc_idx] <= step_sum;
          if (step_ovf_mul || step_ovf_add) ovf <= 1'b1;
          s <= s + 3'd1;
          if (s == 3'(MAC_STEPS - 1)) begin
            // The last step's sum is still in flight, so take it directly.
            for (int n = 0; n < 4; n++)
              c_r[n] <= (2'(n) == acc_idx) ? step_sum : acc_r[n];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_mac_2x2.sv
// tb/tb_block_mac_2x2.sv - scoreboard bench for block_mac_2x2
module tb_block_mac_2x2;

  typedef logic [31:0] quad_t [4];

  typedef struct packed {
    logic [31:0] c11;
    logic [31:0] c12;
    logic [31:0] c21;
    logic [31:0] c22;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        acc_clr = 1'b0;
  logic [31:0] a_11 = '0, a_12 = '0, a_21 = '0, a_22 = '0;
  logic [31:0] b_11 = '0, b_12 = '0, b_21 = '0, b_22 = '0;
  logic        busy, done, ovf;
  logic [31:0] c_11, c_12, c_21, c_22;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  quad_t prev_c;

  block_mac_2x2 #(.DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .acc_clr (acc_clr),
    .a_11    (a_11),
    .a_12    (a_12),
    .a_21    (a_21),
    .a_22    (a_22),
    .b_11    (b_11),
    .b_12    (b_12),
    .b_21    (b_21),
    .b_22    (b_22),
    .busy    (busy),
    .done    (done),
    .c_11    (c_11),
    .c_12    (c_12),
    .c_21    (c_21),
    .c_22    (c_22),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("c_11", c_11, e.c11);
          chk("c_12", c_12, e.c12);
          chk("c_21", c_21, e.c21);
          chk("c_22", c_22, e.c22);
          chk("ovf", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  // mode 0: plain run; 1: start pokes during MUL and DONE; 2: reset at step 4.
  task automatic run_op(input quad_t a, input quad_t b, input bit clr,
                        input quad_t e, input bit eovf, input int mode);
    @(negedge clk);
    a_11 = a[0]; a_12 = a[1]; a_21 = a[2]; a_22 = a[3];
    b_11 = b[0]; b_12 = b[1]; b_21 = b[2]; b_22 = b[3];
    acc_clr = clr;
    start = 1'b1;
    if (mode != 2) sb.push_back('{e[0], e[1], e[2], e[3], eovf});
    @(posedge clk);
    #1;
    start = 1'b0;
    a_11 = 32'hDEAD0001; a_12 = 32'hDEAD0002; a_21 = 32'hDEAD0003; a_22 = 32'hDEAD0004;
    b_11 = 32'hBEEF0001; b_12 = 32'hBEEF0002; b_21 = 32'hBEEF0003; b_22 = 32'hBEEF0004;
    acc_clr = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", n), 32'(busy), (n <= 9) ? 32'd1 : 32'd0);
      chk($sformatf("done_c%0d", n), 32'(done), (n == 9) ? 32'd1 : 32'd0);
      if (n <= 8) begin
        chk($sformatf("hold_c11_c%0d", n), c_11, prev_c[0]);
        chk($sformatf("hold_c22_c%0d", n), c_22, prev_c[3]);
      end
      if (mode == 1 && (n == 3 || n == 9)) begin
        a_11 = 32'd9; a_12 = 32'd9; a_21 = 32'd9; a_22 = 32'd9;
        b_11 = 32'd9; b_12 = 32'd9; b_21 = 32'd9; b_22 = 32'd9;
        acc_clr = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (mode == 2 && n == 5) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_c11", c_11, 32'd0);
        chk("rst_c12", c_12, 32'd0);
        chk("rst_c21", c_21, 32'd0);
        chk("rst_c22", c_22, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        prev_c = '{32'd0, 32'd0, 32'd0, 32'd0};
        return;
      end
    end
    prev_c = e;
  endtask

  initial begin
    prev_c = '{32'd0, 32'd0, 32'd0, 32'd0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_c11", c_11, 32'd0);
    chk("reset_c22", c_22, 32'd0);

    // basic multiply
    run_op('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b1,
           '{32'd19, 32'd22, 32'd43, 32'd50}, 1'b0, 0);
    // accumulate onto previous result
    run_op('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b0,
           '{32'd38, 32'd44, 32'd86, 32'd100}, 1'b0, 0);
    // signed operands
    run_op('{32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF}, '{32'd2, 32'd3, 32'd4, 32'd5}, 1'b1,
           '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFB}, 1'b0, 0);
    // product overflow
    run_op('{32'h40000000, 32'd0, 32'd0, 32'd0}, '{32'd2, 32'd0, 32'd0, 32'd0}, 1'b1,
           '{32'h80000000, 32'd0, 32'd0, 32'd0}, 1'b1, 0);
    // accumulate again: 0x80000000 + 0x80000000 wraps to 0, ovf stays set
    run_op('{32'h40000000, 32'd0, 32'd0, 32'd0}, '{32'd2, 32'd0, 32'd0, 32'd0}, 1'b0,
           '{32'd0, 32'd0, 32'd0, 32'd0}, 1'b1, 0);
    // acc_clr run clears ovf; start pokes during MUL and DONE are ignored
    run_op('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b1,
           '{32'd19, 32'd22, 32'd43, 32'd50}, 1'b0, 1);
    // reset at step 4 discards the partial result
    run_op('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b0,
           '{32'd0, 32'd0, 32'd0, 32'd0}, 1'b0, 2);
    // recovery run after reset
    run_op('{32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF}, '{32'd2, 32'd3, 32'd4, 32'd5}, 1'b1,
           '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFB}, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
